dmem_responder: RTL and testbench

Data-side memory responder for the pipelined RV32I core: the target end of the dmem request interface driven by the memory stage. It accepts one word-aligned read or write at a time, applies byte write masks to a local word-addressed store, and returns `dmem_resp` after a configurable number of wait cycles. It stands in for the data cache/memory behind the memory stage in simulation and in small FPGA builds.

---
 rtl/dmem_responder_pkg.sv | 16 +
 rtl/dmem_responder_array.sv | 45 ++++
 rtl/dmem_responder.sv | 161 ++++++++++++++++
 tb/tb_dmem_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: the RV32I word type and the
// response FSM state encoding.
package dmem_responder_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 4;

   typedef logic [XLEN-1:0] rv32i_word;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_rsp_state_t;

endpackage : dmem_responder_pkg

// File: rtl/dmem_responder_array.sv
// Word-addressed storage with byte-lane write enables and a registered,
// single-port read. The read register is the responder's dmem_rdata.
module dmem_responder_array
   import dmem_responder_pkg::*;
#(
   parameter int unsigned ADDR_BITS = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we_i,
   input  logic [3:0]           wmask_i,
   input  logic [ADDR_BITS-1:0] idx_i,
   input  logic [XLEN-1:0]      wdata_i,
   input  logic                 re_i,
   input  logic                 rzero_i,
   output logic [XLEN-1:0]      rdata_o
);

   localparam int unsigned DEPTH = 32'd1 << ADDR_BITS;

   logic [XLEN-1:0] mem_q [DEPTH];
   logic [XLEN-1:0] rdata_q;

   // Store contents survive reset; only the write is suppressed while rst is high.
   always_ff @(posedge clk) begin
      if (!rst && we_i) begin
         for (int i = 0; i < 4; i++) begin
            if (wmask_i[i]) begin
               mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= rzero_i ? '0 : mem_q[idx_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule : dmem_responder_array

// File: rtl/dmem_responder.sv
// Data-side memory responder: accepts one dmem request at a time, performs it
// against a local store and pulses dmem_resp after LATENCY cycles.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned ADDR_BITS = 10,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned LATENCY   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] dmem_address,
   input  logic        dmem_read,
   input  logic        dmem_write,
   input  logic [31:0] dmem_wdata,
   input  logic [3:0]  dmem_wmask,
   output logic [31:0] dmem_rdata,
   output logic        dmem_resp,
   output logic        dmem_err,
   output logic        busy
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   dmem_rsp_state_t        state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [ADDR_BITS-1:0]   idx_q, idx_d;
   logic [XLEN-1:0]        wdata_q, wdata_d;
   logic [3:0]             wmask_q, wmask_d;
   logic                   write_q, write_d;
   logic                   oor_q, oor_d;
   logic                   cap_err_q, cap_err_d;
   logic                   resp_q, resp_d;
   logic                   err_q, err_d;
   logic                   busy_q, busy_d;

   logic [29:0]            req_off_c;
   logic [ADDR_BITS-1:0]   req_idx_c;
   logic                   req_oor_c;
   logic                   unused_addr_bits;

   logic                   acc_en_c;
   logic [ADDR_BITS-1:0]   acc_idx_c;
   logic [XLEN-1:0]        acc_wdata_c;
   logic [3:0]             acc_wmask_c;
   logic                   acc_write_c;
   logic                   acc_oor_c;
   logic                   acc_err_c;

   // Word offset from BASE_ADDR; anything above the store depth (or below base,
   // which wraps high) is out of range.
   assign req_off_c        = dmem_address[31:2] - BASE_ADDR[31:2];
   assign req_idx_c        = req_off_c[ADDR_BITS-1:0];
   assign req_oor_c        = |req_off_c[29:ADDR_BITS];
   assign unused_addr_bits = &{1'b0, dmem_address[1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         wdata_q   <= '0;
         wmask_q   <= '0;
         write_q   <= 1'b0;
         oor_q     <= 1'b0;
         cap_err_q <= 1'b0;
         resp_q    <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         wdata_q   <= wdata_d;
         wmask_q   <= wmask_d;
         write_q   <= write_d;
         oor_q     <= oor_d;
         cap_err_q <= cap_err_d;
         resp_q    <= resp_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
      end
   end

   // Next state; the store access fires on the edge that enters RESP.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      wdata_d     = wdata_q;
      wmask_d     = wmask_q;
      write_d     = write_q;
      oor_d       = oor_q;
      cap_err_d   = cap_err_q;
      acc_en_c    = 1'b0;
      acc_idx_c   = idx_q;
      acc_wdata_c = wdata_q;
      acc_wmask_c = wmask_q;
      acc_write_c = write_q;
      acc_oor_c   = oor_q;
      acc_err_c   = cap_err_q;

      case (state_q)
         IDLE: begin
            if (dmem_read || dmem_write) begin
               idx_d     = req_idx_c;
               wdata_d   = dmem_wdata;
               wmask_d   = dmem_wmask;
               write_d   = dmem_write;
               oor_d     = req_oor_c;
               cap_err_d = req_oor_c || (dmem_read && dmem_write);
               cnt_d     = CNT_LOAD;
               if (CNT_LOAD == '0) begin
                  state_d     = RESP;
                  acc_en_c    = 1'b1;
                  acc_idx_c   = req_idx_c;
                  acc_wdata_c = dmem_wdata;
                  acc_wmask_c = dmem_wmask;
                  acc_write_c = dmem_write;
                  acc_oor_c   = req_oor_c;
                  acc_err_c   = req_oor_c || (dmem_read && dmem_write);
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_d == '0) begin
               state_d  = RESP;
               acc_en_c = 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      resp_d = acc_en_c;
      err_d  = acc_en_c && acc_err_c;
      busy_d = (state_d == WAIT);
   end

   dmem_responder_array #(
      .ADDR_BITS (ADDR_BITS)
   ) u_array (
      .clk     (clk),
      .rst     (rst),
      .we_i    (acc_en_c && acc_write_c && !acc_oor_c),
      .wmask_i (acc_wmask_c),
      .idx_i   (acc_idx_c),
      .wdata_i (acc_wdata_c),
      .re_i    (acc_en_c && !acc_write_c),
      .rzero_i (acc_oor_c),
      .rdata_o (dmem_rdata)
   );

   assign dmem_resp = resp_q;
   assign dmem_err  = err_q;
   assign busy      = busy_q;

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder (LATENCY=2) plus a short
// directed pass on a LATENCY=1 instance.
module tb_dmem_responder;

   localparam int          LAT  = 2;
   localparam int          AB   = 10;
   localparam logic [31:0] BASE = 32'h0000_0000;

   typedef struct {
      int          exp_cyc;
      bit          chk_data;
      logic [31:0] exp_data;
      bit          exp_err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic        dm_rd, dm_wr, dm_resp, dm_err, dm_busy;
   logic [3:0]  dm_wmask;
   logic [31:0] d1_addr, d1_wdata, d1_rdata;
   logic        d1_rd, d1_wr, d1_resp, d1_err, d1_busy;
   logic [3:0]  d1_wmask;

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_BITS(AB), .BASE_ADDR(BASE), .LATENCY(LAT)) u_dut (
      .clk(clk), .rst(rst), .dmem_address(dm_addr), .dmem_read(dm_rd),
      .dmem_write(dm_wr), .dmem_wdata(dm_wdata), .dmem_wmask(dm_wmask),
      .dmem_rdata(dm_rdata), .dmem_resp(dm_resp), .dmem_err(dm_err), .busy(dm_busy)
   );

   dmem_responder #(.ADDR_BITS(AB), .BASE_ADDR(BASE), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst), .dmem_address(d1_addr), .dmem_read(d1_rd),
      .dmem_write(d1_wr), .dmem_wdata(d1_wdata), .dmem_wmask(d1_wmask),
      .dmem_rdata(d1_rdata), .dmem_resp(d1_resp), .dmem_err(d1_err), .busy(d1_busy)
   );

   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   int          busy_lo = -1;
   int          busy_hi = -2;
   bit          mon_en = 1'b0;
   exp_t        sb_q[$];
   logic [31:0] ref_mem [1024];
   logic [3:0]  ref_kn  [1024];
   logic [31:0] last_rd;
   bit          last_kn;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   // Reference: byte-addressed window of 4*2^AB bytes, whole-word reads.
   function automatic exp_t model(input bit rd, input bit wr, input logic [31:0] a,
                                  input logic [31:0] d, input logic [3:0] m);
      exp_t        e;
      logic [31:0] diff;
      bit          oor;
      int          idx;
      diff  = a - BASE;
      oor   = (diff >= 32'(4 * 1024));
      idx   = int'(diff / 4);
      e.exp_cyc = 0;
      e.exp_err = oor || (rd && wr);
      if (wr) begin
         if (!oor) begin
            for (int i = 0; i < 4; i++) begin
               if (m[i]) begin
                  ref_mem[idx][8*i +: 8] = d[8*i +: 8];
                  ref_kn[idx][i]         = 1'b1;
               end
            end
         end
      end else if (oor) begin
         last_rd = 32'h0;
         last_kn = 1'b1;
      end else begin
         last_rd = ref_mem[idx];
         last_kn = (ref_kn[idx] == 4'hF);
      end
      e.exp_data = last_rd;
      e.chk_data = last_kn;
      return e;
   endfunction

   // scr: 0 keep inputs, 1 randomize them while waiting, 2 move address to 0x20.
   task automatic req(input bit rd, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] m, input int scr);
      exp_t e;
      bit   got;
      got      = 1'b0;
      dm_rd    = rd;
      dm_wr    = wr;
      dm_addr  = a;
      dm_wdata = d;
      dm_wmask = m;
      e = model(rd, wr, a, d, m);
      e.exp_cyc = cyc + LAT;
      busy_lo   = cyc + 1;
      busy_hi   = cyc + LAT - 1;
      sb_q.push_back(e);
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (dm_resp === 1'b1) got = 1'b1;
         else if (scr == 1) begin
            dm_addr  = $urandom;
            dm_wdata = $urandom;
            dm_wmask = 4'($urandom);
         end else if (scr == 2) dm_addr = 32'h20;
      end
      if (!got) begin
         n_chk++;
         n_fail++;
         $display("FAIL req_timeout: got no resp expected resp by cyc %0d", e.exp_cyc);
      end
      // Keep the request held across the RESP edge so a re-accept would show.
      @(negedge clk);
      dm_rd = 1'b0;
      dm_wr = 1'b0;
   endtask

   task automatic req1(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic [31:0] exp_d, input bit exp_e);
      d1_rd = rd; d1_wr = wr; d1_addr = a; d1_wdata = d; d1_wmask = m;
      @(negedge clk);
      chk("l1_resp_t1", 32'(d1_resp), 32'd1);
      chk("l1_err", 32'(d1_err), 32'(exp_e));
      chk("l1_busy", 32'(d1_busy), 32'd0);
      chk("l1_rdata", d1_rdata, exp_d);
      @(negedge clk);
      d1_rd = 1'b0; d1_wr = 1'b0;
      chk("l1_resp_once", 32'(d1_resp), 32'd0);
   endtask

   // Monitor: busy window, response timing, error and data against the queue.
   always @(negedge clk) begin
      exp_t e;
      bit   exp_b;
      if (mon_en) begin
         exp_b = (cyc >= busy_lo) && (cyc <= busy_hi);
         chk("busy", 32'(dm_busy), 32'(exp_b));
         if (dm_resp === 1'b1) begin
            if (sb_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_resp @cyc %0d: got resp=1 expected 0", cyc);
            end else begin
               e = sb_q.pop_front();
               chk("resp_cycle", 32'(cyc), 32'(e.exp_cyc));
               chk("resp_err", 32'(dm_err), 32'(e.exp_err));
               if (e.chk_data) chk("rdata", dm_rdata, e.exp_data);
            end
         end else begin
            chk("err_without_resp", 32'(dm_err), 32'd0);
            if (sb_q.size() > 0 && cyc >= sb_q[0].exp_cyc) begin
               n_chk++;
               n_fail++;
               $display("FAIL resp_missing @cyc %0d: got resp=%b expected 1", cyc, dm_resp);
               void'(sb_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [31:0] a;
      int          r;
      for (int i = 0; i < 1024; i++) begin
         ref_mem[i] = 32'h0;
         ref_kn[i]  = 4'h0;
      end
      rst = 1'b1;
      dm_rd = 0; dm_wr = 0; dm_addr = 0; dm_wdata = 0; dm_wmask = 0;
      d1_rd = 0; d1_wr = 0; d1_addr = 0; d1_wdata = 0; d1_wmask = 0;
      repeat (3) @(negedge clk);
      chk("rst_resp", 32'(dm_resp), 32'd0);
      chk("rst_err", 32'(dm_err), 32'd0);
      chk("rst_busy", 32'(dm_busy), 32'd0);
      chk("rst_rdata", dm_rdata, 32'h0);
      last_rd = 32'h0;
      last_kn = 1'b1;
      rst     = 1'b0;
      mon_en  = 1'b1;
      @(negedge clk);

      req(0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
      req(1, 0, 32'h10, 32'h0, 4'h0, 0);
      req(0, 1, 32'h20, 32'h1234_5678, 4'hF, 0);
      req(1, 0, 32'h10, 32'h0, 4'h0, 2);
      req(0, 1, 32'h30, 32'h1122_3344, 4'hF, 0);
      req(0, 1, 32'h30, 32'hAA55_66BB, 4'b1001, 0);
      req(1, 0, 32'h30, 32'h0, 4'h0, 0);
      req(0, 1, 32'h0, 32'h0BAD_F00D, 4'hF, 0);
      req(1, 0, BASE + 32'd4096, 32'h0, 4'h0, 0);
      req(0, 1, BASE + 32'd4096, 32'hFFFF_FFFF, 4'hF, 0);
      req(1, 0, 32'h0, 32'h0, 4'h0, 0);
      req(1, 1, 32'h8, 32'h5, 4'hF, 0);
      req(1, 0, 32'h8, 32'h0, 4'h0, 0);
      req(0, 1, 32'h8, 32'h7777_7777, 4'h0, 0);
      req(1, 0, 32'h8, 32'h0, 4'h0, 0);

      // Reset lands on the edge that would enter RESP: nothing may commit.
      req(0, 1, 32'h4, 32'h0, 4'hF, 0);
      dm_wr = 1'b1; dm_addr = 32'h4; dm_wdata = 32'hFFFF_FFFF; dm_wmask = 4'hF;
      busy_lo = cyc + 1;
      busy_hi = cyc + 1;
      @(negedge clk);
      rst   = 1'b1;
      dm_wr = 1'b0;
      @(negedge clk);
      chk("abort_resp", 32'(dm_resp), 32'd0);
      chk("abort_busy", 32'(dm_busy), 32'd0);
      chk("abort_rdata", dm_rdata, 32'h0);
      rst     = 1'b0;
      last_rd = 32'h0;
      last_kn = 1'b1;
      @(negedge clk);
      req(1, 0, 32'h4, 32'h0, 4'h0, 0);

      for (int w = 0; w < 16; w++) req(0, 1, 32'(w * 4), $urandom, 4'hF, 0);
      for (int n = 0; n < 250; n++) begin
         r = int'($urandom_range(0, 15));
         if (r == 0)      a = BASE + 32'd4096 + 32'($urandom_range(0, 255));
         else if (r == 1) a = 32'hFFFF_FFFC;
         else             a = BASE + 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
         r = int'($urandom_range(0, 7));
         req(r < 4, r >= 4, a, $urandom, 4'($urandom), int'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      req1(0, 1, 32'h40, 32'hCAFE_0001, 4'hF, 32'h0, 1'b0);
      req1(1, 0, 32'h40, 32'h0, 4'h0, 32'hCAFE_0001, 1'b0);
      req1(1, 0, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_dmem_responder
